// File: rtl/hex_scroll_display.sv
// Multi-digit seven-segment driver: registered word/mode capture and a tick counter.
// Display modes: static, blink, scroll and leading-zero blanking; active-low segment outputs.
module hex_scroll_display #(
  parameter int DATA_W   = 32,
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [1:0]            mode,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  wrap
);

  localparam int NIB    = DATA_W / 4;
  localparam int MAXOFF = (NIB > DIGITS) ? (NIB - DIGITS) : 0;
  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int OFF_W  = (MAXOFF > 0) ? $clog2(MAXOFF + 1) : 1;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;
  localparam logic [1:0] MODE_LZB    = 2'b11;

  logic [DATA_W-1:0]   word;
  logic [1:0]          mode_r;
  logic [CNT_W-1:0]    cnt;
  logic [OFF_W-1:0]    off;
  logic                ph;
  logic                tick;
  logic [7*DIGITS-1:0] next_hex;
  int                  n;
  logic [3:0]          nib;
  logic                blank;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      4'hF:    seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  // Per-digit glyph selection from the state held before the edge
  always_comb begin
    next_hex = '1;
    n        = 0;
    nib      = 4'h0;
    blank    = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (mode_r == MODE_SCROLL) begin
        n = int'(off) + d;
      end else begin
        n = d;
      end
      nib   = 4'(word >> (4 * n));
      blank = (n >= NIB);
      if ((mode_r == MODE_BLINK) && !ph) begin
        blank = 1'b1;
      end else if ((mode_r == MODE_LZB) && (d > 0) && ((word >> (4 * d)) == '0)) begin
        blank = 1'b1;
      end else begin
        blank = blank;
      end
      next_hex[7*d +: 7] = blank ? 7'h7F : seg7(nib);
    end
  end

  // Capture, tick counter, scroll/blink state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      word    <= '0;
      mode_r  <= MODE_STATIC;
      cnt     <= '0;
      off     <= '0;
      ph      <= 1'b1;
      wrap    <= 1'b0;
      hex_out <= '1;
    end else begin
      hex_out <= next_hex;
      if (load) begin
        word   <= data_in;
        mode_r <= mode;
        cnt    <= '0;
        off    <= '0;
        ph     <= 1'b1;
        wrap   <= 1'b0;
      end else begin
        cnt  <= tick ? '0 : cnt + CNT_W'(1);
        wrap <= 1'b0;
        if (tick) begin
          case (mode_r)
            MODE_BLINK: ph <= ~ph;
            MODE_SCROLL: begin
              // With no hidden nibbles MAXOFF is 0, so every tick is a wrap
              if (off == OFF_W'(MAXOFF)) begin
                off  <= '0;
                wrap <= 1'b1;
              end else begin
                off <= off + OFF_W'(1);
              end
            end
            default: ph <= ph;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_scroll_display.sv
// Bench for hex_scroll_display (32-bit word, 6 digits, tick every 4 cycles):
// a cycle model feeds an expectation queue, plus directed glyph checks.
module tb_hex_scroll_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] data_in;
  logic [1:0]  mode;
  logic [41:0] hex_out;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [41:0] hex;
    logic        wrap;
  } exp_t;
  exp_t q[$];

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state
  logic [31:0] m_word = 32'h0;
  logic [1:0]  m_mode = 2'b00;
  int          m_cnt  = 0;
  int          m_off  = 0;
  logic        m_ph   = 1'b1;

  hex_scroll_display #(.DATA_W(32), .DIGITS(6), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .mode(mode), .hex_out(hex_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] model_hex(logic [31:0] w, logic [1:0] md, int o, logic p);
    logic [41:0] r;
    logic [3:0]  nibs [8];
    int          idx;
    bit          hi_zero;
    for (int i = 0; i < 8; i++) nibs[i] = w[4*i +: 4];
    for (int d = 0; d < 6; d++) begin
      idx = (md == 2'b10) ? o + d : d;
      hi_zero = 1'b1;
      for (int j = d; j < 8; j++) if (nibs[j] != 4'h0) hi_zero = 1'b0;
      if (idx > 7 || (md == 2'b01 && !p) || (md == 2'b11 && d > 0 && hi_zero))
        r[7*d +: 7] = 7'h7F;
      else
        r[7*d +: 7] = glyph[nibs[idx]];
    end
    return r;
  endfunction

  task automatic cycle(input logic rst, input logic ld, input logic [31:0] din, input logic [1:0] md);
    exp_t e, got;
    reset = rst; load = ld; data_in = din; mode = md;
    @(posedge clk);
    if (rst) begin
      e.hex = {42{1'b1}}; e.wrap = 1'b0;
      m_word = 32'h0; m_mode = 2'b00; m_cnt = 0; m_off = 0; m_ph = 1'b1;
    end else begin
      e.hex = model_hex(m_word, m_mode, m_off, m_ph);
      e.wrap = 1'b0;
      if (ld) begin
        m_word = din; m_mode = md; m_cnt = 0; m_off = 0; m_ph = 1'b1;
      end else if (m_cnt == 3) begin
        m_cnt = 0;
        if (m_mode == 2'b01) m_ph = ~m_ph;
        if (m_mode == 2'b10) begin
          if (m_off == 2) begin m_off = 0; e.wrap = 1'b1; end
          else m_off = m_off + 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    q.push_back(e);
    #1;
    got = q.pop_front();
    checks++;
    assert (hex_out === got.hex) else begin
      errors++;
      $error("FAIL model_hex observed=%h expected=%h", hex_out, got.hex);
    end
    checks++;
    assert (wrap === got.wrap) else begin
      errors++;
      $error("FAIL model_wrap observed=%b expected=%b", wrap, got.wrap);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 2'b00);
  endtask

  task automatic check_hex(input string tag, input logic [41:0] exp);
    checks++;
    assert (hex_out === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, hex_out, exp);
    end
  endtask

  task automatic check_wrap(input string tag, input logic exp);
    checks++;
    assert (wrap === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, wrap, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = 32'h0; mode = 2'b00;

    // 1: reset then release
    cycle(1'b1, 1'b0, 32'h0, 2'b00);
    cycle(1'b1, 1'b0, 32'h0, 2'b00);
    check_hex("reset_blank", {6{7'h7F}});
    idle(1);
    check_hex("post_reset_zero", {6{7'h40}});
    idle(2);

    // 2: static C0FFEE
    cycle(1'b0, 1'b1, 32'h00C0FFEE, 2'b00);
    check_hex("static_stale", {6{7'h40}});
    idle(1);
    check_hex("static_coffee", {7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06});
    idle(20);
    check_hex("static_stable", {7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06});

    // 3: leading-zero blanking
    cycle(1'b0, 1'b1, 32'h000000A5, 2'b11);
    idle(1);
    check_hex("lzb_a5", {{4{7'h7F}}, 7'h08, 7'h12});
    cycle(1'b0, 1'b1, 32'h00000000, 2'b11);
    idle(1);
    check_hex("lzb_zero", {{5{7'h7F}}, 7'h40});

    // 4: scroll
    cycle(1'b0, 1'b1, 32'h12345678, 2'b10);
    idle(1);
    check_hex("scroll_off0", {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    idle(4);
    check_hex("scroll_off1", {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78});
    idle(4);
    check_hex("scroll_off2", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    idle(3);
    check_wrap("scroll_wrap_hi", 1'b1);
    idle(1);
    check_wrap("scroll_wrap_lo", 1'b0);
    check_hex("scroll_back0", {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});

    // 5: blink, re-load in the off phase
    cycle(1'b0, 1'b1, 32'hFFFFFFFF, 2'b01);
    idle(4);
    check_hex("blink_on", {6{7'h0E}});
    idle(1);
    check_hex("blink_off", {6{7'h7F}});
    idle(9);
    check_hex("blink_off2", {6{7'h7F}});
    cycle(1'b0, 1'b1, 32'hFFFFFFFF, 2'b01);
    idle(1);
    check_hex("blink_reload_on", {6{7'h0E}});
    idle(9);

    // 6a: reset at off=2 mid-scroll
    cycle(1'b0, 1'b1, 32'h12345678, 2'b10);
    idle(9);
    check_hex("pre_reset_off2", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 2'b00);
      check_wrap("reset_no_wrap", 1'b0);
    end
    idle(2);
    check_hex("after_reset_zero", {6{7'h40}});

    // 6b: load in a tick cycle at off=2
    cycle(1'b0, 1'b1, 32'h12345678, 2'b10);
    idle(11);
    cycle(1'b0, 1'b1, 32'h12345678, 2'b10);
    check_wrap("load_tick_no_wrap", 1'b0);
    idle(1);
    check_hex("load_tick_off0", {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    idle(3);

    // 6c: reset with load
    cycle(1'b1, 1'b1, 32'hABCDEF12, 2'b00);
    idle(1);
    check_hex("reset_beats_load", {6{7'h40}});
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
